// File: rtl/ysyx_22050039_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU data-memory arbiter:
// bus widths, FSM state encoding and requester ids.
package ysyx_22050039_mem_arbiter_pkg;

  localparam int XLEN   = 64;
  localparam int MASK_W = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/ysyx_22050039_mem_arbiter_if.sv
// Arbiter bus: IFU and LSU request/response channels plus the memory port.
// master = arbiter view, slave = requesters and memory model view.
interface ysyx_22050039_mem_arbiter_if;
  import ysyx_22050039_mem_arbiter_pkg::*;

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [XLEN-1:0]   ifu_req_addr;
  logic              ifu_resp_valid;
  logic [XLEN-1:0]   ifu_resp_data;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [XLEN-1:0]   lsu_req_addr;
  logic              lsu_req_wen;
  logic [XLEN-1:0]   lsu_req_wdata;
  logic [MASK_W-1:0] lsu_req_wmask;
  logic              lsu_resp_valid;
  logic [XLEN-1:0]   lsu_resp_data;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [XLEN-1:0]   mem_req_addr;
  logic              mem_req_wen;
  logic [XLEN-1:0]   mem_req_wdata;
  logic [MASK_W-1:0] mem_req_wmask;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_resp_data;

  modport master (
    input  ifu_req_valid, ifu_req_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen,
    input  lsu_req_wdata, lsu_req_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    output mem_req_valid, mem_req_addr, mem_req_wen,
    output mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    output ifu_req_valid, ifu_req_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen,
    output lsu_req_wdata, lsu_req_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    input  mem_req_valid, mem_req_addr, mem_req_wen,
    input  mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );

endinterface

// File: rtl/ysyx_22050039_rr_arb2.sv
// Two-way round-robin arbiter: req[0]=IFU, req[1]=LSU, last = previous winner.
// On a tie the requester that did not win last time is granted (one-hot).
module ysyx_22050039_rr_arb2
  import ysyx_22050039_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == OWN_LSU) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_22050039_mem_arbiter.sv
// Shares one data-memory port between IFU and LSU, one transaction in flight.
// Ports: clk, rst (sync, active-high), bus (master modport), protocol_err.
module ysyx_22050039_mem_arbiter
  import ysyx_22050039_mem_arbiter_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  ysyx_22050039_mem_arbiter_if.master  bus,
  output logic                         protocol_err
);

  state_t     state;
  state_t     state_nx;
  logic       last_grant;
  logic       owner;
  logic [1:0] grant;
  logic       accept;
  logic       resp_hit;

  ysyx_22050039_rr_arb2 u_arb (
    .req   ({bus.lsu_req_valid, bus.ifu_req_valid}),
    .last  (last_grant),
    .grant (grant)
  );

  always_comb begin
    state_nx          = state;
    bus.ifu_req_ready = 1'b0;
    bus.lsu_req_ready = 1'b0;
    bus.mem_req_valid = 1'b0;
    accept            = 1'b0;
    unique case (state)
      IDLE: begin
        bus.ifu_req_ready = grant[0];
        bus.lsu_req_ready = grant[1];
        accept            = |grant;
        if (accept) state_nx = REQ;
      end
      REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_nx = WAIT;
      end
      WAIT: begin
        if (bus.mem_resp_valid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign resp_hit = (state == WAIT) && bus.mem_resp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      last_grant         <= OWN_IFU;
      owner              <= OWN_IFU;
      bus.mem_req_addr   <= '0;
      bus.mem_req_wen    <= 1'b0;
      bus.mem_req_wdata  <= '0;
      bus.mem_req_wmask  <= '0;
      bus.ifu_resp_valid <= 1'b0;
      bus.ifu_resp_data  <= '0;
      bus.lsu_resp_valid <= 1'b0;
      bus.lsu_resp_data  <= '0;
      protocol_err       <= 1'b0;
    end else begin
      state              <= state_nx;
      bus.ifu_resp_valid <= resp_hit && (owner == OWN_IFU);
      bus.lsu_resp_valid <= resp_hit && (owner == OWN_LSU);
      if (accept) begin
        owner      <= grant[1];
        last_grant <= grant[1];
        if (grant[1]) begin
          bus.mem_req_addr  <= bus.lsu_req_addr;
          bus.mem_req_wen   <= bus.lsu_req_wen;
          bus.mem_req_wdata <= bus.lsu_req_wdata;
          bus.mem_req_wmask <= bus.lsu_req_wmask;
        end else begin
          bus.mem_req_addr  <= bus.ifu_req_addr;
          bus.mem_req_wen   <= 1'b0;
          bus.mem_req_wdata <= '0;
          bus.mem_req_wmask <= '0;
        end
      end
      if (resp_hit && (owner == OWN_IFU))
        bus.ifu_resp_data <= bus.mem_resp_data;
      // A store ack carries no data.
      if (resp_hit && (owner == OWN_LSU))
        bus.lsu_resp_data <= bus.mem_req_wen ? '0 : bus.mem_resp_data;
      if (bus.mem_resp_valid && (state != WAIT))
        protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_22050039_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter: a table of
// zero-wait transactions plus stall, protocol-error and reset sequences.
module tb_ysyx_22050039_mem_arbiter;

  logic clk;
  logic rst;
  logic protocol_err;
  int   checks;
  int   errors;

  ysyx_22050039_mem_arbiter_if bus ();

  ysyx_22050039_mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ifu_v;
    logic        lsu_v;
    logic [63:0] ifu_addr;
    logic [63:0] lsu_addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] mem_data;
    logic        own;
    logic [63:0] exp_data;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_req_addr   = '0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_req_addr   = '0;
    bus.lsu_req_wen    = 1'b0;
    bus.lsu_req_wdata  = '0;
    bus.lsu_req_wmask  = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
  endtask

  // Zero-wait transaction: accept t, mem req t+1, mem resp t+2, resp t+3.
  task automatic run_vec(input vec_t v, input string tag);
    logic [63:0] ea;
    bus.ifu_req_valid = v.ifu_v;
    bus.ifu_req_addr  = v.ifu_addr;
    bus.lsu_req_valid = v.lsu_v;
    bus.lsu_req_addr  = v.lsu_addr;
    bus.lsu_req_wen   = v.wen;
    bus.lsu_req_wdata = v.wdata;
    bus.lsu_req_wmask = v.wmask;
    #1;
    chk({tag, " ifu_ready"}, 64'(bus.ifu_req_ready), 64'(v.own == 1'b0));
    chk({tag, " lsu_ready"}, 64'(bus.lsu_req_ready), 64'(v.own == 1'b1));
    step();
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    ea = v.own ? v.lsu_addr : v.ifu_addr;
    chk({tag, " mem_valid"}, 64'(bus.mem_req_valid), 64'd1);
    chk({tag, " mem_addr"}, bus.mem_req_addr, ea);
    chk({tag, " mem_wen"}, 64'(bus.mem_req_wen), 64'(v.own & v.wen));
    chk({tag, " mem_wmask"}, 64'(bus.mem_req_wmask),
        v.own ? 64'(v.wmask) : 64'd0);
    if (v.own) chk({tag, " mem_wdata"}, bus.mem_req_wdata, v.wdata);
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = v.mem_data;
    chk({tag, " mem_valid_wait"}, 64'(bus.mem_req_valid), 64'd0);
    step();
    bus.mem_resp_valid = 1'b0;
    chk({tag, " ifu_resp_valid"}, 64'(bus.ifu_resp_valid),
        64'(v.own == 1'b0));
    chk({tag, " lsu_resp_valid"}, 64'(bus.lsu_resp_valid),
        64'(v.own == 1'b1));
    if (v.own) chk({tag, " lsu_resp_data"}, bus.lsu_resp_data, v.exp_data);
    else       chk({tag, " ifu_resp_data"}, bus.ifu_resp_data, v.exp_data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{1, 1, 64'h8000_0000, 64'h8000_0100, 0, 64'h0, 8'h00,
                64'h0123_4567_89AB_CDEF, 1, 64'h0123_4567_89AB_CDEF};
    vecs[1] = '{1, 1, 64'h8000_0000, 64'h8000_0100, 0, 64'h0, 8'h00,
                64'hDEAD_BEEF_0000_0013, 0, 64'hDEAD_BEEF_0000_0013};
    vecs[2] = '{1, 1, 64'h8000_0000, 64'h8000_0108, 0, 64'h0, 8'h00,
                64'hCAFE_F00D_1234_5678, 1, 64'hCAFE_F00D_1234_5678};
    vecs[3] = '{1, 0, 64'h8000_0004, 64'h0, 0, 64'h0, 8'h00,
                64'h0000_0000_0010_0093, 0, 64'h0000_0000_0010_0093};
    vecs[4] = '{1, 0, 64'h8000_0008, 64'h0, 0, 64'h0, 8'h00,
                64'h0000_0000_0000_0073, 0, 64'h0000_0000_0000_0073};
    vecs[5] = '{0, 1, 64'h0, 64'h8000_0300, 1, 64'hA5A5_A5A5_5A5A_5A5A,
                8'hFF, 64'h0000_0000_0000_1234, 1, 64'h0};
    vecs[6] = '{0, 1, 64'h0, 64'h8000_0310, 0, 64'h0, 8'h00,
                64'h0000_0000_0000_0077, 1, 64'h0000_0000_0000_0077};
    vecs[7] = '{1, 1, 64'h8000_000C, 64'h8000_0318, 0, 64'h0, 8'h00,
                64'h0000_0000_0000_0013, 0, 64'h0000_0000_0000_0013};

    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst ifu_ready", 64'(bus.ifu_req_ready), 64'd0);
    chk("rst lsu_ready", 64'(bus.lsu_req_ready), 64'd0);
    chk("rst mem_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("rst mem_addr", bus.mem_req_addr, 64'd0);
    chk("rst ifu_resp", 64'(bus.ifu_resp_valid), 64'd0);
    chk("rst lsu_resp", 64'(bus.lsu_resp_valid), 64'd0);
    chk("rst ifu_data", bus.ifu_resp_data, 64'd0);
    chk("rst perr", 64'(protocol_err), 64'd0);

    for (int i = 0; i < NV; i++)
      run_vec(vecs[i], $sformatf("v%0d", i));

    // Store with a three-cycle mem_req_ready stall and a late response.
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = 64'h8000_0200;
    bus.lsu_req_wen   = 1'b1;
    bus.lsu_req_wdata = 64'h1122_3344_5566_7788;
    bus.lsu_req_wmask = 8'h0F;
    #1;
    chk("st lsu_ready", 64'(bus.lsu_req_ready), 64'd1);
    step();
    bus.lsu_req_valid = 1'b0;
    bus.lsu_req_addr  = 64'hFFFF_0000_FFFF_0000;
    bus.lsu_req_wdata = 64'h0;
    bus.lsu_req_wmask = 8'hF0;
    for (int i = 0; i <= 3; i++) begin
      chk($sformatf("st%0d mem_valid", i), 64'(bus.mem_req_valid), 64'd1);
      chk($sformatf("st%0d addr", i), bus.mem_req_addr, 64'h8000_0200);
      chk($sformatf("st%0d wdata", i), bus.mem_req_wdata,
          64'h1122_3344_5566_7788);
      chk($sformatf("st%0d wmask", i), 64'(bus.mem_req_wmask), 64'h0F);
      chk($sformatf("st%0d wen", i), 64'(bus.mem_req_wen), 64'd1);
      if (i == 3) bus.mem_req_ready = 1'b1;
      step();
    end
    bus.mem_req_ready = 1'b0;
    chk("st wait mem_valid", 64'(bus.mem_req_valid), 64'd0);
    step();
    chk("st no early resp", 64'(bus.lsu_resp_valid), 64'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    bus.mem_resp_valid = 1'b0;
    chk("st lsu_resp", 64'(bus.lsu_resp_valid), 64'd1);
    chk("st lsu_data", bus.lsu_resp_data, 64'd0);
    chk("st ifu_resp", 64'(bus.ifu_resp_valid), 64'd0);
    step();
    chk("st pulse end", 64'(bus.lsu_resp_valid), 64'd0);
    chk("st data hold", bus.lsu_resp_data, 64'd0);
    chk("st ifu hold", bus.ifu_resp_data, 64'h13);
    chk("st perr", 64'(protocol_err), 64'd0);

    // Stray response while idle.
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 64'h5555_5555_5555_5555;
    step();
    bus.mem_resp_valid = 1'b0;
    chk("pe perr", 64'(protocol_err), 64'd1);
    chk("pe ifu_resp", 64'(bus.ifu_resp_valid), 64'd0);
    chk("pe lsu_resp", 64'(bus.lsu_resp_valid), 64'd0);
    step();
    step();
    chk("pe sticky", 64'(protocol_err), 64'd1);
    run_vec('{1, 0, 64'h8000_0000, 64'h0, 0, 64'h0, 8'h00,
              64'hDEAD_BEEF_0000_0013, 0, 64'hDEAD_BEEF_0000_0013}, "pe");
    chk("pe sticky2", 64'(protocol_err), 64'd1);

    // Reset in WAIT, then the orphan response arrives.
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 64'h8000_0020;
    step();
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rw mem_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("rw perr clr", 64'(protocol_err), 64'd0);
    chk("rw ifu_data", bus.ifu_resp_data, 64'd0);
    chk("rw mem_addr", bus.mem_req_addr, 64'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 64'h0BAD_0BAD_0BAD_0BAD;
    step();
    bus.mem_resp_valid = 1'b0;
    chk("rw ifu_resp", 64'(bus.ifu_resp_valid), 64'd0);
    chk("rw lsu_resp", 64'(bus.lsu_resp_valid), 64'd0);
    chk("rw perr", 64'(protocol_err), 64'd1);
    step();
    chk("rw ifu_resp2", 64'(bus.ifu_resp_valid), 64'd0);
    run_vec('{1, 1, 64'h8000_0024, 64'h8000_0400, 0, 64'h0, 8'h00,
              64'h0000_0000_0000_0042, 1, 64'h0000_0000_0000_0042}, "rw");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22050039_mem_arbiter.md
# ysyx_22050039_mem_arbiter

Two-requester arbiter sharing the single data-memory port between the IFU (instruction fetch, read-only) and the LSU (loads/stores issued by the EXU). It replaces the direct per-unit `pmem_read` calls with one valid/ready request channel and one response channel to the memory model. It keeps one transaction outstanding, uses round-robin priority on ties, and routes each response back to the requester that issued it.

## Interface
- XLEN, 64, address/data width
- MASK_W, XLEN/8, write byte-mask width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  XLEN  fetch address
- ifu_resp_valid  out  1  one-cycle pulse, fetch data valid
- ifu_resp_data  out  XLEN  fetched doubleword
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  XLEN  load/store address
- lsu_req_wen  in  1  1 = store, 0 = load
- lsu_req_wdata  in  XLEN  store data
- lsu_req_wmask  in  MASK_W  store byte mask
- lsu_resp_valid  out  1  one-cycle pulse, load data or store ack
- lsu_resp_data  out  XLEN  load doubleword; 0 for store ack
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr / mem_req_wen / mem_req_wdata / mem_req_wmask  out  XLEN/1/XLEN/MASK_W  latched request fields
- mem_resp_valid  in  1  memory response (reads and writes)
- mem_resp_data  in  XLEN  read data
- protocol_err  out  1  sticky; mem_resp_valid arrived outside WAIT

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE: winner's `*_req_ready` = 1, driven combinationally from valids and last_grant. On handshake, latch addr/wen/wdata/wmask, set owner and last_grant, then go to REQ. An IFU request latches wen=0 and wmask=0.
- Arbitration in IDLE: a single valid requester wins. If both are valid, the one not equal to last_grant wins. last_grant resets to IFU, so LSU wins the first tie.
- At most one `*_req_ready` is high in any cycle. Both are 0 in REQ and WAIT.
- REQ: mem_req_valid = 1 with the latched fields held stable. On mem_req_ready go to WAIT.
- WAIT: on mem_resp_valid, register the data into the owner's resp_data, pulse the owner's resp_valid next cycle, and go to IDLE. LSU store ack: lsu_resp_data = 0.
- Requesters always accept responses; there is no response backpressure.
- mem_resp_valid in IDLE or REQ is ignored and sets protocol_err, which holds until rst.
- rst, including mid-transaction: state = IDLE, last_grant = IFU, any in-flight response is dropped, protocol_err = 0.

## Timing
- Reset value of every output is 0, including ready and data buses.
- Handshake at cycle t (IDLE) → mem_req_valid high from t+1.
- mem_req_ready at cycle r → WAIT from r+1. A mem_resp_valid in cycle r itself is a protocol error.
- mem_resp_valid at cycle k (WAIT) → owner resp_valid = 1 at k+1 for exactly one cycle. FSM is in IDLE at k+1, so a new request can be accepted at k+1.
- Minimum turnaround, zero-wait memory: accept t, mem request t+1, memory response t+2, requester response t+3. Next accept is also at t+3.
- Non-owner resp_valid stays 0. resp_data holds its last value between pulses.
- mem_req_* fields are constant from REQ entry to the mem_req_ready handshake.

## Structure
- Shared include header (alongside the instruction-encoding header): FSM state encoding (2-bit IDLE/REQ/WAIT), owner encoding (OWN_IFU = 0, OWN_LSU = 1), MASK_W default.
- Sub-module ysyx_22050039_rr_arb2: combinational 2-way round-robin arbiter. Inputs: req[1:0] and last; output: one-hot grant.
- FSM, latch registers, response registers and protocol_err live in the top module.

## Test plan
- Reset, then IFU fetch addr 0x8000_0000 with memory ready immediately and data 0xDEAD_BEEF_0000_0013 → ifu_resp_valid at t+3 with that data; lsu_resp_valid stays 0.
- IFU and LSU both valid from reset (LSU load 0x8000_0100) → LSU granted first, then IFU; responses arrive in that order. Repeating the tie alternates grants.
- LSU store addr 0x8000_0200, wdata 0x1122_3344_5566_7788, wmask 0x0F, memory stalls mem_req_ready for 3 cycles → fields held stable; lsu_resp_valid pulses once with data 0.
- mem_resp_valid injected in IDLE → protocol_err = 1 and stays 1. No resp_valid pulse; the next normal transaction completes correctly.
- rst asserted during WAIT, then the old mem_resp_valid arrives after reset is released → dropped, no resp pulse, protocol_err = 1. A fresh request is granted normally afterwards.
